snake_tick_sequencer: RTL and testbench
=======================================

# snake_tick_sequencer

Game-level controller that sequences the snake movement datapath. It watches the pixel scan coordinates to detect frame ends and issues one-cycle `update_tick` move commands every `frames_per_move` frames. It filters player direction requests, rejecting 180° reversals, and owns the IDLE/RUN/OVER game state. It also keeps the score and raises speed as apples are eaten. It sits between the input decoder and the head/apple position logic, replacing free-running frame counting inside that logic.

## Interface
Parameters:
- `H_LAST`, 639, last visible x coordinate
- `V_LAST`, 479, last visible y coordinate
- `INIT_FRAMES`, 5, frames per move after start (3-bit, 1..7)
- `MIN_FRAMES`, 1, fastest allowed frames per move
- `APPLES_PER_LEVEL`, 4, apples eaten per speed step
- `INIT_DIR`, 2'd2, direction on start (RIGHT)

Ports:
- `clk`  in  1  system/pixel clock; one clock domain only
- `reset`  in  1  synchronous, active-high reset
- `x_in`, `y_in`  in  10 each  current scan coordinates, one new pair per clock
- `start`  in  1  start/restart request (level; sampled each cycle)
- `dir_req`  in  2  requested direction: 0 LEFT, 1 TOP, 2 RIGHT, 3 DOWN
- `dir_req_valid`  in  1  `dir_req` qualifier, single-cycle
- `collision`  in  1  head hit body (from datapath)
- `apple_eaten`  in  1  one-cycle pulse from datapath
- `update_tick`  out  1  one-cycle move command to datapath
- `direction`  out  2  committed direction used by datapath at `update_tick`
- `game_running`  out  1  high in RUN
- `is_game_finished`  out  1  high in OVER
- `score`  out  8  apples eaten, saturating
- `frames_per_move`  out  3  current speed setting

## Operation
- Reset (synchronous, when `reset` is high at a `clk` edge) puts the block in IDLE:
  - `update_tick`=0, `direction`=`INIT_DIR`, pending direction=`INIT_DIR`
  - `game_running`=0, `is_game_finished`=0
  - `score`=0, `frames_per_move`=`INIT_FRAMES`
  - frame counter=0, level counter=0
  - reset mid-game aborts the game immediately
- FSM states:
  - IDLE: `start`=1 → RUN; counters/score/direction reinitialised to reset values.
  - RUN: `collision`=1 → OVER.
  - OVER: `start`=1 → RUN with the same reinit as from IDLE.
  - No other transitions.
- Frame end: `x_in`==`H_LAST` && `y_in`==`V_LAST`, in any state. Registered as `frame_end_q`.
- Tick generation (RUN only):
  - On `frame_end_q`, if frame counter == `frames_per_move`-1: counter←0 and `update_tick`=1 for exactly one cycle.
  - Otherwise counter+1 (3-bit).
- Direction filter (RUN only):
  - `dir_req_valid` with `dir_req` != (`direction` ^ 2'b10) → pending←`dir_req`.
  - A reversal is dropped.
  - Several accepted requests between ticks: the last one wins.
  - Reversal is checked against the committed direction, not the pending one.
- Commit: in the same cycle `update_tick` is driven high, `direction`←pending. The datapath sees the new direction together with the tick.
- Apple (RUN only):
  - `score`+1, saturating at 255.
  - Level counter+1. On reaching `APPLES_PER_LEVEL` it clears, and `frames_per_move` decrements if > `MIN_FRAMES`.
- Simultaneous events:
  - `collision` and a tick due in the same cycle: tick suppressed, go to OVER.
  - `collision` and `apple_eaten` in the same cycle: score still counts, then OVER.
  - `start` in RUN is ignored.
  - IDLE/OVER ignore `dir_req_valid`, `apple_eaten` and `collision`.

## Timing
- Frame-end coordinate at cycle N → `frame_end_q` at N+1 → `update_tick` and new `direction` at N+2.
- `collision` at cycle N → `is_game_finished`=1, `game_running`=0 at N+1. No tick at N+1 or later.
- `start` at N → `game_running`=1 at N+1. First tick `INIT_FRAMES` frame ends later.
- `apple_eaten` at N → `score`/`frames_per_move` updated at N+1. A new speed applies from the next counter comparison.
- All outputs registered; no combinational input→output paths.

## Structure
- Direction codes, reversal mask 2'b10 and state encodings (IDLE=0, RUN=1, OVER=2) go in the shared definitions header alongside the existing screen/square constants.
- `H_LAST`/`V_LAST` defaults match the shared last-address constants.
- One natural sub-module: `snake_dir_filter` (pending register, reversal check, commit on tick).
- The FSM, frame counter and score logic stay in the top.

## Test plan
- Reset, then `start` pulse, scan 640×480 frames with `INIT_FRAMES`=5 → first `update_tick` 2 cycles after the 5th frame end; then one every 5 frames; `direction`=2.
- `direction`=2, request 0 (LEFT) → dropped. Request 1 then 3 in one frame → `direction`=3 at the next tick, not before.
- 4 `apple_eaten` pulses → `score`=4, `frames_per_move`=4. Repeat to 16 apples → floors at 1; 300 apples → `score`=255.
- `collision` in the same cycle as a due tick → no `update_tick`; `is_game_finished`=1 next cycle; later ticks absent.
- In OVER, pulse `start` → RUN with `score`=0, `frames_per_move`=5, `direction`=2.
- Assert `reset` mid-RUN between ticks → next cycle IDLE, all outputs at reset values, no further ticks.

Source files
------------

// File: rtl/snake_tick_sequencer_pkg.sv
// Shared snake game definitions: screen geometry, direction codes and game states.
package snake_tick_sequencer_pkg;

    localparam int unsigned H_RES       = 640;
    localparam int unsigned V_RES       = 480;
    localparam int unsigned SQUARE_SIZE = 20;
    localparam int unsigned H_LAST_ADDR = H_RES - 1;
    localparam int unsigned V_LAST_ADDR = V_RES - 1;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned DIR_W   = 2;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned FPM_W   = 3;
    localparam int unsigned LVL_W   = 8;

    typedef enum logic [DIR_W-1:0] {
        DIR_LEFT  = 2'd0,
        DIR_TOP   = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    // Opposite directions differ only in the upper bit
    localparam logic [DIR_W-1:0] DIR_REV_MASK = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_e;

    function automatic logic is_reversal(input logic [DIR_W-1:0] req,
                                         input logic [DIR_W-1:0] cur);
        return req == (cur ^ DIR_REV_MASK);
    endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// Holds the pending player direction, drops 180-degree reversals and
// commits the pending direction on each move tick.
module snake_dir_filter
    import snake_tick_sequencer_pkg::*;
#(
    parameter logic [DIR_W-1:0] INIT_DIR = DIR_RIGHT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reinit,
    input  logic             enable,
    input  logic [DIR_W-1:0] dir_req,
    input  logic             dir_req_valid,
    input  logic             commit,
    output logic [DIR_W-1:0] direction
);

    logic [DIR_W-1:0] pending_q, pending_d;
    logic [DIR_W-1:0] direction_q, direction_d;

    always_comb begin
        pending_d   = pending_q;
        direction_d = direction_q;
        if (reinit) begin
            pending_d   = INIT_DIR;
            direction_d = INIT_DIR;
        end else if (enable) begin
            if (commit) begin
                direction_d = pending_q;
            end
            // Reversal is judged against what the datapath is moving in now
            if (dir_req_valid && !is_reversal(dir_req, direction_q)) begin
                pending_d = dir_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= INIT_DIR;
            direction_q <= INIT_DIR;
        end else begin
            pending_q   <= pending_d;
            direction_q <= direction_d;
        end
    end

    assign direction = direction_q;

endmodule

// File: rtl/snake_tick_sequencer.sv
// Game-level controller: frame-end detection, move tick generation,
// IDLE/RUN/OVER state, score and speed levels.
module snake_tick_sequencer
    import snake_tick_sequencer_pkg::*;
#(
    parameter int unsigned      H_LAST           = H_LAST_ADDR,
    parameter int unsigned      V_LAST           = V_LAST_ADDR,
    parameter int unsigned      INIT_FRAMES      = 5,
    parameter int unsigned      MIN_FRAMES       = 1,
    parameter int unsigned      APPLES_PER_LEVEL = 4,
    parameter logic [DIR_W-1:0] INIT_DIR         = DIR_RIGHT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic               start,
    input  logic [DIR_W-1:0]   dir_req,
    input  logic               dir_req_valid,
    input  logic               collision,
    input  logic               apple_eaten,
    output logic               update_tick,
    output logic [DIR_W-1:0]   direction,
    output logic               game_running,
    output logic               is_game_finished,
    output logic [SCORE_W-1:0] score,
    output logic [FPM_W-1:0]   frames_per_move
);

    game_state_e        state_q, state_d;
    logic               frame_end_q, frame_end_d;
    logic [FPM_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [LVL_W-1:0]   level_cnt_q, level_cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [FPM_W-1:0]   fpm_q, fpm_d;
    logic               update_tick_q, update_tick_d;
    logic               game_running_q, game_running_d;
    logic               finished_q, finished_d;
    logic               reinit_c;
    logic               tick_fire_c;

    always_comb begin
        state_d        = state_q;
        frame_end_d    = (x_in == COORD_W'(H_LAST)) && (y_in == COORD_W'(V_LAST));
        frame_cnt_d    = frame_cnt_q;
        level_cnt_d    = level_cnt_q;
        score_d        = score_q;
        fpm_d          = fpm_q;
        reinit_c       = 1'b0;
        tick_fire_c    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_RUN;
                    frame_cnt_d = '0;
                    level_cnt_d = '0;
                    score_d     = '0;
                    fpm_d       = FPM_W'(INIT_FRAMES);
                    reinit_c    = 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_end_q) begin
                    if (frame_cnt_q == FPM_W'(fpm_q - 3'd1)) begin
                        frame_cnt_d = '0;
                        tick_fire_c = !collision;
                    end else begin
                        frame_cnt_d = FPM_W'(frame_cnt_q + 3'd1);
                    end
                end
                if (apple_eaten) begin
                    if (score_q != '1) begin
                        score_d = SCORE_W'(score_q + 8'd1);
                    end
                    if (LVL_W'(level_cnt_q + 8'd1) == LVL_W'(APPLES_PER_LEVEL)) begin
                        level_cnt_d = '0;
                        if (fpm_q > FPM_W'(MIN_FRAMES)) begin
                            fpm_d = FPM_W'(fpm_q - 3'd1);
                        end
                    end else begin
                        level_cnt_d = LVL_W'(level_cnt_q + 8'd1);
                    end
                end
                if (collision) begin
                    state_d = ST_OVER;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        update_tick_d  = tick_fire_c;
        game_running_d = (state_d == ST_RUN);
        finished_d     = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            frame_end_q    <= 1'b0;
            frame_cnt_q    <= '0;
            level_cnt_q    <= '0;
            score_q        <= '0;
            fpm_q          <= FPM_W'(INIT_FRAMES);
            update_tick_q  <= 1'b0;
            game_running_q <= 1'b0;
            finished_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_end_q    <= frame_end_d;
            frame_cnt_q    <= frame_cnt_d;
            level_cnt_q    <= level_cnt_d;
            score_q        <= score_d;
            fpm_q          <= fpm_d;
            update_tick_q  <= update_tick_d;
            game_running_q <= game_running_d;
            finished_q     <= finished_d;
        end
    end

    snake_dir_filter #(
        .INIT_DIR (INIT_DIR)
    ) u_dir_filter (
        .clk           (clk),
        .reset         (reset),
        .reinit        (reinit_c),
        .enable        (state_q == ST_RUN),
        .dir_req       (dir_req),
        .dir_req_valid (dir_req_valid),
        .commit        (tick_fire_c),
        .direction     (direction)
    );

    assign update_tick      = update_tick_q;
    assign game_running     = game_running_q;
    assign is_game_finished = finished_q;
    assign score            = score_q;
    assign frames_per_move  = fpm_q;

endmodule

// File: tb/tb_snake_tick_sequencer.sv
// Randomized bench for snake_tick_sequencer against a behavioural game model.
module tb_snake_tick_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x_in, y_in;
    logic       start;
    logic [1:0] dir_req;
    logic       dir_req_valid;
    logic       collision;
    logic       apple_eaten;
    logic       update_tick;
    logic [1:0] direction;
    logic       game_running;
    logic       is_game_finished;
    logic [7:0] score;
    logic [2:0] frames_per_move;

    always #5 clk = ~clk;

    snake_tick_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .x_in             (x_in),
        .y_in             (y_in),
        .start            (start),
        .dir_req          (dir_req),
        .dir_req_valid    (dir_req_valid),
        .collision        (collision),
        .apple_eaten      (apple_eaten),
        .update_tick      (update_tick),
        .direction        (direction),
        .game_running     (game_running),
        .is_game_finished (is_game_finished),
        .score            (score),
        .frames_per_move  (frames_per_move)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Model: game phase 0 idle / 1 playing / 2 finished; speed and score
    // follow from the number of apples eaten since the game started.
    int m_state, m_fe, m_cnt, m_apples, m_dir, m_pend, m_tick;

    function automatic int m_speed();
        int s;
        s = 5 - m_apples / 4;
        return (s < 1) ? 1 : s;
    endfunction

    function automatic int m_score();
        return (m_apples > 255) ? 255 : m_apples;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int fe_now, old_pend, old_dir, sp;
        fe_now = (x_in == 10'd639 && y_in == 10'd479) ? 1 : 0;
        if (reset) begin
            m_state = 0; m_fe = 0; m_cnt = 0; m_apples = 0;
            m_dir = 2; m_pend = 2; m_tick = 0;
            return;
        end
        m_tick = 0;
        if (m_state == 1) begin
            sp       = m_speed();
            old_pend = m_pend;
            old_dir  = m_dir;
            if (m_fe != 0) begin
                if (m_cnt == sp - 1) begin
                    m_cnt = 0;
                    if (!collision) begin
                        m_tick = 1;
                        m_dir  = old_pend;
                    end
                end else begin
                    m_cnt = (m_cnt + 1) % 8;
                end
            end
            if (dir_req_valid && int'(dir_req) != (old_dir ^ 2)) m_pend = int'(dir_req);
            if (apple_eaten) m_apples++;
            if (collision) m_state = 2;
        end else if (start) begin
            m_state = 1; m_cnt = 0; m_apples = 0; m_dir = 2; m_pend = 2;
        end
        m_fe = fe_now;
    endtask

    task automatic check_all();
        chk("tick",  update_tick, m_tick);
        chk("dir",   direction, m_dir);
        chk("run",   game_running, (m_state == 1));
        chk("over",  is_game_finished, (m_state == 2));
        chk("score", score, m_score());
        chk("fpm",   frames_per_move, m_speed());
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_coords(input bit fe);
        if (fe) begin
            x_in = 10'd639;
            y_in = 10'd479;
        end else begin
            x_in = 10'($urandom_range(0, 638));
            y_in = 10'($urandom_range(0, 479));
        end
    endtask

    task automatic quiet_inputs();
        start = 1'b0; dir_req = 2'd0; dir_req_valid = 1'b0;
        collision = 1'b0; apple_eaten = 1'b0;
        set_coords(0);
    endtask

    task automatic run_frames(input int n, output int ticks);
        ticks = 0;
        for (int f = 0; f < n; f++) begin
            set_coords(1); cyc(); ticks += int'(update_tick);
            set_coords(0); cyc(); ticks += int'(update_tick);
            cyc();                ticks += int'(update_tick);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks;
        bit found;
        reset = 1'b1;
        quiet_inputs();
        cyc();
        cyc();
        chk("rst_fpm", frames_per_move, 5);
        chk("rst_dir", direction, 2);
        reset = 1'b0;
        cyc();

        // Start and first tick after the fifth frame end
        start = 1'b1; cyc(); start = 1'b0;
        chk("start_run", game_running, 1);
        for (int f = 0; f < 5; f++) begin
            set_coords(1); cyc();
            if (f == 4) chk("tick_early", update_tick, 0);
            set_coords(0); cyc();
            if (f == 4) chk("first_tick", update_tick, 1);
            cyc();
        end
        run_frames(10, ticks);
        chk("tick_count", ticks, 2);

        // Reversal drop, then last accepted request wins at the next tick
        dir_req = 2'd0; dir_req_valid = 1'b1; cyc(); dir_req_valid = 1'b0;
        run_frames(5, ticks);
        chk("rev_drop", direction, 2);
        dir_req = 2'd1; dir_req_valid = 1'b1; cyc();
        dir_req = 2'd3; cyc(); dir_req_valid = 1'b0;
        cyc();
        chk("dir_hold", direction, 2);
        run_frames(5, ticks);
        chk("dir_commit", direction, 3);

        // Apples: speed steps, floor and score saturation
        for (int a = 1; a <= 300; a++) begin
            apple_eaten = 1'b1; cyc(); apple_eaten = 1'b0; cyc();
            if (a == 4) begin
                chk("score4", score, 4);
                chk("fpm4", frames_per_move, 4);
            end
            if (a == 16) chk("fpm_floor", frames_per_move, 1);
        end
        chk("score_sat", score, 255);
        run_frames(3, ticks);

        // Collision landing exactly on a due tick
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            set_coords((c % 3) == 0);
            collision = (m_state == 1 && m_fe != 0 && m_cnt == m_speed() - 1);
            if (collision) begin
                cyc();
                collision = 1'b0;
                chk("coll_no_tick", update_tick, 0);
                chk("coll_over", is_game_finished, 1);
                found = 1;
            end else begin
                cyc();
            end
        end
        chk("coll_found", found, 1);
        run_frames(4, ticks);
        chk("over_no_ticks", ticks, 0);

        // Restart from OVER
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_score", score, 0);
        chk("restart_fpm", frames_per_move, 5);
        chk("restart_dir", direction, 2);
        chk("restart_run", game_running, 1);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            set_coords($urandom_range(0, 3) == 0);
            dir_req       = 2'($urandom_range(0, 3));
            dir_req_valid = ($urandom_range(0, 2) == 0);
            apple_eaten   = ($urandom_range(0, 19) == 0);
            collision     = ($urandom_range(0, 399) == 0);
            start         = ($urandom_range(0, 49) == 0);
            reset         = ($urandom_range(0, 999) == 0);
            cyc();
        end
        quiet_inputs();
        reset = 1'b0;
        cyc();

        // Reset mid-game between ticks
        start = 1'b1; cyc(); start = 1'b0;
        apple_eaten = 1'b1; cyc(); apple_eaten = 1'b0;
        run_frames(2, ticks);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("mid_rst_run", game_running, 0);
        chk("mid_rst_over", is_game_finished, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_fpm", frames_per_move, 5);
        chk("mid_rst_tick", update_tick, 0);
        run_frames(8, ticks);
        chk("idle_no_ticks", ticks, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
